// File: rtl/char_motion_ctrl.sv
// Character motion sequencer.
// Turns the left/right/jump buttons into walking, a charged jump, ballistic
// airborne motion with wall bounce, and landing on a platform or the ground.
// All motion advances once per physics tick, a one-cycle pulse generated
// every TICK_N sys_clk cycles. Positions are unsigned pixels with y pointing
// up (height above ground); velocities are signed pixels per tick.
//
// The state output is the FSM state (0 IDLE, 1 CHARGE, 2 AIR, 3 LAND), so
// checkers can bind to it directly.
module char_motion_ctrl #(
    parameter int PHY_WIDTH    = 14,
    parameter int VEL_WIDTH    = 8,
    parameter int TICK_N       = 1000000,
    parameter int MAP_WIDTH_X  = 480,
    parameter int WALL_WIDTH   = 10,
    parameter int CHAR_WIDTH_X = 42,
    parameter int X_INIT       = 219,
    parameter int WALK_STEP    = 2,
    parameter int H_VEL        = 3,
    parameter int BASE_VEL     = 4,
    parameter int JUMP_GAIN    = 1,
    parameter int MAX_CHARGE   = 15,
    parameter int GRAVITY      = 1,
    parameter int MAX_FALL     = 12
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 left_btn,
    input  logic                 right_btn,
    input  logic                 jump_btn,
    input  logic                 land_req,
    input  logic [PHY_WIDTH-1:0] land_y,
    output logic [PHY_WIDTH-1:0] char_x,
    output logic [PHY_WIDTH-1:0] char_y,
    output logic [1:0]           state,
    output logic                 facing,
    output logic [3:0]           charge,
    output logic                 tick
);

    // Counter width for the tick divider; at least one bit.
    localparam int CNT_W = (TICK_N > 1) ? $clog2(TICK_N) : 1;
    // Airborne arithmetic is done two bits wider than the position so that
    // overshoot past either wall or below the ground is representable.
    localparam int AW    = PHY_WIDTH + 2;
    localparam int XMIN  = WALL_WIDTH;
    localparam int XMAX  = MAP_WIDTH_X - WALL_WIDTH - CHAR_WIDTH_X;

    localparam logic signed [AW-1:0]        C_XMIN   = AW'(XMIN);
    localparam logic signed [AW-1:0]        C_XMAX   = AW'(XMAX);
    localparam logic [PHY_WIDTH-1:0]        C_XMIN_P = PHY_WIDTH'(XMIN);
    localparam logic [PHY_WIDTH-1:0]        C_XMAX_P = PHY_WIDTH'(XMAX);
    localparam logic signed [VEL_WIDTH-1:0] C_VY_MIN = VEL_WIDTH'(-MAX_FALL);
    localparam logic signed [VEL_WIDTH-1:0] C_HVEL   = VEL_WIDTH'(H_VEL);
    localparam logic [3:0]                  C_CHMAX  = 4'(MAX_CHARGE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHARGE = 2'd1,
        S_AIR    = 2'd2,
        S_LAND   = 2'd3
    } state_t;

    // Synchronizer flops (meta stage, then usable stage)
    logic r_left_meta, r_left_sync;
    logic r_right_meta, r_right_sync;
    logic r_jump_meta, r_jump_sync;

    // Tick divider
    logic [CNT_W-1:0] r_tick_cnt;
    logic             w_tick;

    // Motion state
    state_t                        r_state;
    logic [PHY_WIDTH-1:0]          r_x;
    logic [PHY_WIDTH-1:0]          r_y;
    logic signed [VEL_WIDTH-1:0]   r_vx;
    logic signed [VEL_WIDTH-1:0]   r_vy;
    logic                          r_facing;
    logic [3:0]                    r_charge;

    // Combinational next-value helpers
    logic                          w_left_only;
    logic                          w_right_only;
    logic [PHY_WIDTH-1:0]          w_walk_left_x;
    logic [PHY_WIDTH-1:0]          w_walk_right_x;
    logic signed [VEL_WIDTH-1:0]   w_launch_vy;
    logic signed [VEL_WIDTH-1:0]   w_launch_vx;
    logic signed [AW-1:0]          w_x_ext;
    logic signed [AW-1:0]          w_vx_ext;
    logic signed [AW-1:0]          w_x_sum;
    logic [PHY_WIDTH-1:0]          w_air_x;
    logic signed [VEL_WIDTH-1:0]   w_air_vx;
    logic signed [AW-1:0]          w_y_ext;
    logic signed [AW-1:0]          w_vy_ext;
    logic signed [AW-1:0]          w_y_sum;
    logic [PHY_WIDTH-1:0]          w_air_y;
    logic                          w_hit_ground;
    logic                          w_land_plat;
    logic signed [VEL_WIDTH-1:0]   w_vy_dec;
    logic signed [VEL_WIDTH-1:0]   w_air_vy;

    // Two-flop synchronizers for the asynchronous button levels
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_left_meta  <= 1'b0;
            r_left_sync  <= 1'b0;
            r_right_meta <= 1'b0;
            r_right_sync <= 1'b0;
            r_jump_meta  <= 1'b0;
            r_jump_sync  <= 1'b0;
        end else begin
            r_left_meta  <= left_btn;
            r_left_sync  <= r_left_meta;
            r_right_meta <= right_btn;
            r_right_sync <= r_right_meta;
            r_jump_meta  <= jump_btn;
            r_jump_sync  <= r_jump_meta;
        end
    end

    // Physics tick divider: counts 0..TICK_N-1, tick asserted on the last count
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign w_tick = (r_tick_cnt == CNT_W'(TICK_N - 1));

    // Ground movement helpers: walk with clamping at the inner wall faces,
    // and the launch velocities taken when the jump button is released
    always_comb begin
        w_left_only  = r_left_sync & ~r_right_sync;
        w_right_only = r_right_sync & ~r_left_sync;

        w_walk_left_x = C_XMIN_P;
        if (r_x >= C_XMIN_P + PHY_WIDTH'(WALK_STEP)) begin
            w_walk_left_x = r_x - PHY_WIDTH'(WALK_STEP);
        end

        w_walk_right_x = C_XMAX_P;
        if (r_x + PHY_WIDTH'(WALK_STEP) <= C_XMAX_P) begin
            w_walk_right_x = r_x + PHY_WIDTH'(WALK_STEP);
        end

        w_launch_vy = VEL_WIDTH'(BASE_VEL) + VEL_WIDTH'(JUMP_GAIN) * VEL_WIDTH'(r_charge);

        w_launch_vx = '0;
        if (w_right_only) begin
            w_launch_vx = C_HVEL;
        end else if (w_left_only) begin
            w_launch_vx = -C_HVEL;
        end
    end

    // Airborne helpers: horizontal move with wall reflection, vertical move
    // with ground/platform detection, gravity and fall-speed limit
    always_comb begin
        w_x_ext  = {2'b00, r_x};
        w_vx_ext = {{(AW-VEL_WIDTH){r_vx[VEL_WIDTH-1]}}, r_vx};
        w_x_sum  = w_x_ext + w_vx_ext;

        w_air_x  = w_x_sum[PHY_WIDTH-1:0];
        w_air_vx = r_vx;
        if (w_x_sum > C_XMAX) begin
            w_air_x  = C_XMAX_P;
            w_air_vx = -r_vx;
        end else if (w_x_sum < C_XMIN) begin
            w_air_x  = C_XMIN_P;
            w_air_vx = -r_vx;
        end

        w_y_ext  = {2'b00, r_y};
        w_vy_ext = {{(AW-VEL_WIDTH){r_vy[VEL_WIDTH-1]}}, r_vy};
        w_y_sum  = w_y_ext + w_vy_ext;

        // A platform can only catch the character on the way down (vy <= 0).
        w_land_plat  = land_req & (r_vy[VEL_WIDTH-1] | (r_vy == '0));
        w_hit_ground = w_y_sum[AW-1];

        // Non-negative sum: any bit at or above PHY_WIDTH means overflow.
        w_air_y = w_y_sum[PHY_WIDTH-1:0];
        if (w_y_sum[PHY_WIDTH]) begin
            w_air_y = {PHY_WIDTH{1'b1}};
        end

        w_vy_dec = r_vy - VEL_WIDTH'(GRAVITY);
        w_air_vy = w_vy_dec;
        if (w_vy_dec < C_VY_MIN) begin
            w_air_vy = C_VY_MIN;
        end
    end

    // Motion FSM: every state and position update happens on the tick cycle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state  <= S_IDLE;
            r_x      <= PHY_WIDTH'(X_INIT);
            r_y      <= '0;
            r_vx     <= '0;
            r_vy     <= '0;
            r_facing <= 1'b1;
            r_charge <= '0;
        end else if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    // Jump takes priority over walking.
                    if (r_jump_sync) begin
                        r_state  <= S_CHARGE;
                        r_charge <= '0;
                    end else if (w_left_only) begin
                        r_x      <= w_walk_left_x;
                        r_facing <= 1'b0;
                    end else if (w_right_only) begin
                        r_x      <= w_walk_right_x;
                        r_facing <= 1'b1;
                    end
                end
                S_CHARGE: begin
                    if (r_jump_sync) begin
                        if (r_charge < C_CHMAX) begin
                            r_charge <= r_charge + 4'd1;
                        end
                    end else begin
                        r_state  <= S_AIR;
                        r_vy     <= w_launch_vy;
                        r_vx     <= w_launch_vx;
                        r_charge <= '0;
                        if (w_right_only) begin
                            r_facing <= 1'b1;
                        end else if (w_left_only) begin
                            r_facing <= 1'b0;
                        end
                    end
                end
                S_AIR: begin
                    r_x <= w_air_x;
                    if (w_land_plat) begin
                        r_y     <= land_y;
                        r_vy    <= '0;
                        r_vx    <= '0;
                        r_state <= S_LAND;
                    end else if (w_hit_ground) begin
                        r_y     <= '0;
                        r_vy    <= '0;
                        r_vx    <= '0;
                        r_state <= S_LAND;
                    end else begin
                        r_y  <= w_air_y;
                        r_vy <= w_air_vy;
                        r_vx <= w_air_vx;
                    end
                end
                S_LAND: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign char_x = r_x;
    assign char_y = r_y;
    assign state  = r_state;
    assign facing = r_facing;
    assign charge = r_charge;
    assign tick   = w_tick;

endmodule
